node_multicast_engine: RTL and testbench
========================================

# node_multicast_engine

Parametrised packet engine for a NoC node, placed between the node's compute logic and the router interface (IF). It latches a multi-word payload and sends it as one packet to each destination selected in a mask, running the IF request/ack handshake once per destination. It also reassembles inbound flits into a receive buffer and reports packet completion and overflow. It generalises the fixed two-flit, single-destination node send path to variable length, multicast, and a receive side.

## Interface
- DATA_W, 32, payload bits per flit
- FLIT_W, 73, inbound flit width; bit FLIT_W-1 = valid, bit FLIT_W-2 = tail, bits [DATA_W-1:0] = data
- ID_W, 8, node id width
- MAX_FLITS, 8, max words per packet, ≥1
- NUM_DEST, 4, destination slots
- LEN_W, $clog2(MAX_FLITS+1), length/count width

Ports:
- N_clk  in  1  clock; all state on rising edge
- N_rst  in  1  asynchronous, active-high reset
- local_id  in  ID_W  this node's id; driven on src_node
- start  in  1  one-cycle request to begin a multicast
- dest_mask  in  NUM_DEST  destinations to serve, sampled at start
- dest_ids  in  NUM_DEST*ID_W  slot i id at [i*ID_W +: ID_W], sampled at start
- pkt_len  in  LEN_W  words per packet, sampled at start
- tx_payload  in  MAX_FLITS*DATA_W  word k at [k*DATA_W +: DATA_W], sampled at start
- busy  out  1  multicast in progress
- tx_done  out  1  one-cycle pulse after the final word of the final destination
- send_req  out  1  IF send request
- req_ack  in  1  IF grant
- send_data_valid  out  1  send_data holds a valid word
- send_data  out  DATA_W  outbound word
- src_node  out  ID_W  registered copy of local_id
- dest_node  out  ID_W  current destination id
- i_flit  in  FLIT_W  inbound flit from the IF
- rx_clear  in  1  clears the receive state
- rx_data  out  MAX_FLITS*DATA_W  receive buffer, same packing as tx_payload
- rx_count  out  LEN_W  words stored in the current packet
- rx_done  out  1  one-cycle pulse after a tail flit is accepted
- rx_overflow  out  1  sticky; a flit arrived while the buffer was full

## Operation
- Reset: every output is 0, the TX FSM is IDLE, and the RX buffer is zeroed.
- TX FSM states: IDLE, REQ, SEND, DONE.
- IDLE:
  - A start with pkt_len in 1..MAX_FLITS and dest_mask≠0 latches the payload, mask, ids and length, then goes to REQ.
  - Otherwise start is ignored; no outputs change.
- REQ:
  - Current slot = lowest set bit of the latched mask.
  - send_req=1; dest_node = that slot's id.
  - When req_ack is sampled 1, go to SEND.
- SEND:
  - send_data_valid=1 for exactly pkt_len consecutive cycles, carrying words 0..pkt_len-1 in order.
  - No backpressure; the word index wraps to 0 at the end of each packet.
  - After the last word, clear the slot's mask bit. Go to REQ if any bit remains, otherwise go to DONE.
- DONE: tx_done=1 for one cycle, then go to IDLE.
- start is ignored while busy.
- req_ack outside REQ is ignored.
- RX, on each flit with the valid bit set:
  - If rx_count<MAX_FLITS: write data to word rx_count and increment rx_count.
  - Otherwise set rx_overflow and drop the data.
  - If the tail bit is set, pulse rx_done and close the packet. The next valid flit restarts at word 0 with count 1; other buffer words are not cleared.
- rx_clear zeroes rx_count, rx_overflow and the open/closed flag; rx_data is retained.
- rx_clear together with a valid flit: the clear applies first, then the flit is stored at word 0 and rx_count=1.
- TX and RX are independent and may run concurrently.

## Timing
- All outputs are registered.
- start sampled at edge T: busy=1, send_req=1 and dest_node valid from T+1.
- req_ack sampled 1 at edge E: send_req=0 and send_data_valid=1 with word 0 from E+1.
- Word k appears at E+1+k.
- Last word at cycle L:
  - If more destinations remain, send_req=1 with the new dest_node at L+1.
  - Otherwise tx_done=1 at L+1, and busy=0 from L+2.
- Per-destination overhead: 1 request cycle (ack in the first cycle) + pkt_len data cycles.
- A flit valid at edge F appears in rx_data/rx_count at F+1; rx_done, if a tail, is also at F+1.
- An overflow flit sets rx_overflow at F+1; if it is a tail, rx_done still pulses.
- N_rst asserted mid-operation: outputs go to 0 immediately (asynchronously). The operation is lost and is not resumed.

## Test plan
- Unicast: pkt_len=2, mask=4'b0001, id0=4, payload {0x80010001, 0xFFFFFFFF}, ack one cycle after req → words 0xFFFFFFFF, 0x80010001 on consecutive cycles, dest_node=4, src_node=local_id=7, tx_done 1 cycle after, busy low next.
- Multicast: mask=4'b1010, ids {9,3,2,1}, pkt_len=3, ack delayed 2 cycles each → destination 2 then 9, each with 3 words, no valid cycles between ack and data, single tx_done.
- Ignored starts: start with pkt_len=0, then with mask=0, then a second start while busy → no req on the first two, the in-flight multicast unaffected by the third.
- RX reassembly: 3 flits, third tail, data 0xA,0xB,0xC → rx_count=3, rx_data words 0..2 = A,B,C, rx_done at the cycle after the tail. The next flit 0xD → word 0 = D, rx_count=1.
- RX overflow/clear: MAX_FLITS=8, send 9 flits (last tail) → rx_count=8, rx_overflow=1, rx_done pulse. rx_clear together with flit 0xE → rx_overflow=0, rx_count=1, word 0 = 0xE.
- Reset: N_rst pulsed mid-SEND → all outputs 0 immediately (asynchronously). After release, a fresh start works normally.

Source files
------------

// File: rtl/node_multicast_engine.sv
// NoC node packet engine: multicast TX of a latched payload over the
// router req/ack handshake, plus inbound flit reassembly into an RX buffer.
module node_multicast_engine #(
    parameter int DATA_W    = 32,
    parameter int FLIT_W    = 73,
    parameter int ID_W      = 8,
    parameter int MAX_FLITS = 8,
    parameter int NUM_DEST  = 4,
    parameter int LEN_W     = $clog2(MAX_FLITS + 1)
) (
    input  logic                          N_clk,
    input  logic                          N_rst,
    input  logic [ID_W-1:0]               local_id,
    input  logic                          start,
    input  logic [NUM_DEST-1:0]           dest_mask,
    input  logic [NUM_DEST*ID_W-1:0]      dest_ids,
    input  logic [LEN_W-1:0]              pkt_len,
    input  logic [MAX_FLITS*DATA_W-1:0]   tx_payload,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          send_req,
    input  logic                          req_ack,
    output logic                          send_data_valid,
    output logic [DATA_W-1:0]             send_data,
    output logic [ID_W-1:0]               src_node,
    output logic [ID_W-1:0]               dest_node,
    input  logic [FLIT_W-1:0]             i_flit,
    input  logic                          rx_clear,
    output logic [MAX_FLITS*DATA_W-1:0]   rx_data,
    output logic [LEN_W-1:0]              rx_count,
    output logic                          rx_done,
    output logic                          rx_overflow
);

    typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;

    state_t                        state_q, state_d;
    logic [NUM_DEST-1:0]           mask_q, mask_d, slot_q;
    logic [NUM_DEST*ID_W-1:0]      ids_q, ids_src;
    logic [LEN_W-1:0]              len_q, idx_q, idx_d;
    logic [MAX_FLITS*DATA_W-1:0]   pay_q;
    logic                          start_ok, load, last_word;

    logic                          busy_d, req_d, vld_d, done_d;
    logic [DATA_W-1:0]             data_d;
    logic [ID_W-1:0]               dest_d;

    assign start_ok = start && (pkt_len != '0)
                    && (pkt_len <= LEN_W'(MAX_FLITS))
                    && (|dest_mask);
    assign load      = (state_q == IDLE) && start_ok;
    assign slot_q    = mask_q & (~mask_q + NUM_DEST'(1));
    assign last_word = idx_q == (len_q - LEN_W'(1));
    assign ids_src   = load ? dest_ids : ids_q;

    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_ok) state_d = REQ;
            REQ:  if (req_ack) state_d = SEND;
            SEND: begin
                if (last_word)
                    state_d = |(mask_q & ~slot_q) ? REQ : DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the word/slot bookkeeping
    always_comb begin
        mask_d = mask_q;
        idx_d  = idx_q;
        if (load) mask_d = dest_mask;
        if (state_q == REQ) idx_d = '0;
        if (state_q == SEND) begin
            idx_d = last_word ? '0 : idx_q + LEN_W'(1);
            if (last_word) mask_d = mask_q & ~slot_q;
        end

        busy_d = state_d != IDLE;
        req_d  = state_d == REQ;
        vld_d  = state_d == SEND;
        done_d = state_d == DONE;

        data_d = '0;
        if (vld_d) begin
            for (int k = 0; k < MAX_FLITS; k++)
                if (idx_d == LEN_W'(k))
                    data_d = pay_q[k*DATA_W +: DATA_W];
        end

        dest_d = '0;
        for (int i = NUM_DEST - 1; i >= 0; i--)
            if (mask_d[i]) dest_d = ids_src[i*ID_W +: ID_W];
    end

    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) begin
            mask_q          <= '0;
            ids_q           <= '0;
            len_q           <= '0;
            idx_q           <= '0;
            pay_q           <= '0;
            busy            <= 1'b0;
            send_req        <= 1'b0;
            send_data_valid <= 1'b0;
            tx_done         <= 1'b0;
            send_data       <= '0;
            dest_node       <= '0;
            src_node        <= '0;
        end else begin
            mask_q <= mask_d;
            idx_q  <= idx_d;
            if (load) begin
                ids_q <= dest_ids;
                len_q <= pkt_len;
                pay_q <= tx_payload;
            end
            busy            <= busy_d;
            send_req        <= req_d;
            send_data_valid <= vld_d;
            tx_done         <= done_d;
            send_data       <= data_d;
            dest_node       <= dest_d;
            src_node        <= local_id;
        end
    end

    logic             flit_v, flit_t, rx_closed, has_room;
    logic [LEN_W-1:0] base_cnt;

    assign flit_v = i_flit[FLIT_W-1];
    assign flit_t = i_flit[FLIT_W-2];

    // A clear or a closed packet makes the next flit land at word 0
    assign base_cnt = (rx_clear || rx_closed) ? '0 : rx_count;
    assign has_room = base_cnt < LEN_W'(MAX_FLITS);

    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) begin
            rx_data     <= '0;
            rx_count    <= '0;
            rx_done     <= 1'b0;
            rx_overflow <= 1'b0;
            rx_closed   <= 1'b0;
        end else begin
            rx_done <= flit_v && flit_t;
            if (flit_v) begin
                if (has_room) begin
                    for (int k = 0; k < MAX_FLITS; k++)
                        if (base_cnt == LEN_W'(k))
                            rx_data[k*DATA_W +: DATA_W] <= i_flit[DATA_W-1:0];
                    rx_count <= base_cnt + LEN_W'(1);
                end else begin
                    rx_count <= base_cnt;
                end
                rx_overflow <= (!rx_clear && rx_overflow) || !has_room;
                rx_closed   <= flit_t;
            end else if (rx_clear) begin
                rx_count    <= '0;
                rx_overflow <= 1'b0;
                rx_closed   <= 1'b0;
            end
        end
    end

    generate
        if (FLIT_W - 2 > DATA_W) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^i_flit[FLIT_W-3:DATA_W];
        end
    endgenerate

endmodule

// File: tb/tb_node_multicast_engine.sv
// Scoreboard bench for node_multicast_engine: directed cases from the
// test plan plus randomized concurrent TX/RX traffic.
module tb_node_multicast_engine;

    localparam int DATA_W    = 32;
    localparam int FLIT_W    = 73;
    localparam int ID_W      = 8;
    localparam int MAX_FLITS = 8;
    localparam int NUM_DEST  = 4;
    localparam int LEN_W     = $clog2(MAX_FLITS + 1);
    localparam int PW        = MAX_FLITS * DATA_W;

    logic                     N_clk, N_rst;
    logic [ID_W-1:0]          local_id;
    logic                     start;
    logic [NUM_DEST-1:0]      dest_mask;
    logic [NUM_DEST*ID_W-1:0] dest_ids;
    logic [LEN_W-1:0]         pkt_len;
    logic [PW-1:0]            tx_payload;
    logic                     busy, tx_done, send_req, req_ack;
    logic                     send_data_valid;
    logic [DATA_W-1:0]        send_data;
    logic [ID_W-1:0]          src_node, dest_node;
    logic [FLIT_W-1:0]        i_flit;
    logic                     rx_clear;
    logic [PW-1:0]            rx_data;
    logic [LEN_W-1:0]         rx_count;
    logic                     rx_done, rx_overflow;

    node_multicast_engine #(
        .DATA_W(DATA_W), .FLIT_W(FLIT_W), .ID_W(ID_W),
        .MAX_FLITS(MAX_FLITS), .NUM_DEST(NUM_DEST), .LEN_W(LEN_W)
    ) dut (
        .N_clk(N_clk), .N_rst(N_rst), .local_id(local_id),
        .start(start), .dest_mask(dest_mask), .dest_ids(dest_ids),
        .pkt_len(pkt_len), .tx_payload(tx_payload), .busy(busy),
        .tx_done(tx_done), .send_req(send_req), .req_ack(req_ack),
        .send_data_valid(send_data_valid), .send_data(send_data),
        .src_node(src_node), .dest_node(dest_node), .i_flit(i_flit),
        .rx_clear(rx_clear), .rx_data(rx_data), .rx_count(rx_count),
        .rx_done(rx_done), .rx_overflow(rx_overflow)
    );

    initial N_clk = 1'b0;
    always #5 N_clk = ~N_clk;

    int total = 0;
    int bad   = 0;
    int exp_done  = 0;
    int seen_done = 0;

    typedef struct packed {
        logic [ID_W-1:0]   dest;
        logic [DATA_W-1:0] data;
    } tx_exp_t;

    typedef struct packed {
        logic [LEN_W-1:0] cnt;
        logic [PW-1:0]    buff;
        logic             done;
        logic             ovf;
    } rx_exp_t;

    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];
    tx_exp_t mon_t;
    rx_exp_t mon_r;

    logic [DATA_W-1:0] m_buf[MAX_FLITS];
    int m_cnt;
    bit m_closed, m_ovf;

    task automatic chk(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge N_clk) begin
        if (!N_rst) begin
            if (send_data_valid) begin
                if (tx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_extra_word: got %0h expected none",
                             send_data);
                end else begin
                    mon_t = tx_q.pop_front();
                    chk("tx_data", send_data, mon_t.data);
                    chk("tx_dest", dest_node, mon_t.dest);
                    chk("src_node", src_node, local_id);
                end
            end
            if (tx_done) seen_done++;
        end
    end

    logic rx_evt;
    always @(posedge N_clk or posedge N_rst) begin
        if (N_rst) rx_evt <= 1'b0;
        else       rx_evt <= i_flit[FLIT_W-1] | rx_clear;
    end

    always @(negedge N_clk) begin
        if (!N_rst && rx_evt) begin
            if (rx_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_extra_event: got count %0d expected none",
                         rx_count);
            end else begin
                mon_r = rx_q.pop_front();
                chk("rx_count", rx_count, mon_r.cnt);
                chk("rx_data", rx_data, mon_r.buff);
                chk("rx_done", rx_done, mon_r.done);
                chk("rx_overflow", rx_overflow, mon_r.ovf);
            end
        end else if (!N_rst) begin
            chk("rx_done_idle", rx_done, 0);
        end
    end

    function automatic logic [PW-1:0] rand_pay();
        logic [PW-1:0] p;
        for (int k = 0; k < MAX_FLITS; k++)
            p[k*DATA_W +: DATA_W] = $urandom;
        return p;
    endfunction

    function automatic logic [NUM_DEST*ID_W-1:0] rand_ids();
        logic [NUM_DEST*ID_W-1:0] v;
        for (int k = 0; k < NUM_DEST; k++)
            v[k*ID_W +: ID_W] = ID_W'($urandom);
        return v;
    endfunction

    task automatic scramble_tx_inputs();
        dest_mask  = NUM_DEST'($urandom);
        dest_ids   = rand_ids();
        pkt_len    = LEN_W'($urandom);
        tx_payload = rand_pay();
    endtask

    task automatic rx_model_reset();
        for (int k = 0; k < MAX_FLITS; k++) m_buf[k] = '0;
        m_cnt    = 0;
        m_closed = 0;
        m_ovf    = 0;
    endtask

    // Each destination gets len words in ascending slot order
    task automatic run_tx(input logic [NUM_DEST-1:0] m,
                          input logic [NUM_DEST*ID_W-1:0] ids,
                          input int len, input logic [PW-1:0] pay,
                          input int ack_dly, input bit poke);
        tx_exp_t te;
        int n;
        bit more;
        for (int s = 0; s < NUM_DEST; s++)
            if (m[s])
                for (int w = 0; w < len; w++) begin
                    te.dest = ids[s*ID_W +: ID_W];
                    te.data = pay[w*DATA_W +: DATA_W];
                    tx_q.push_back(te);
                end
        exp_done++;
        dest_mask  = m;
        dest_ids   = ids;
        pkt_len    = LEN_W'(len);
        tx_payload = pay;
        start      = 1'b1;
        @(negedge N_clk);
        start = 1'b0;
        scramble_tx_inputs();
        chk("busy_after_start", busy, 1);
        for (int s = 0; s < NUM_DEST; s++) begin
            if (m[s]) begin
                n = 0;
                while (!send_req && n < 50) begin
                    @(negedge N_clk);
                    n++;
                end
                if (!send_req) begin
                    total++;
                    bad++;
                    $display("FAIL req_timeout: got send_req=0 expected 1");
                    return;
                end
                chk("req_dest", dest_node, ids[s*ID_W +: ID_W]);
                repeat (ack_dly) @(negedge N_clk);
                chk("req_held", send_req, 1);
                req_ack = 1'b1;
                if (poke) begin
                    start     = 1'b1;
                    dest_mask = '1;
                    pkt_len   = LEN_W'(1);
                end
                @(negedge N_clk);
                req_ack = 1'b0;
                start   = 1'b0;
                chk("req_drop", send_req, 0);
                chk("first_word_valid", send_data_valid, 1);
                n = 0;
                while (send_data_valid && n < MAX_FLITS + 2) begin
                    req_ack = 1'($urandom);
                    @(negedge N_clk);
                    n++;
                end
                req_ack = 1'b0;
                chk("word_count", n, len);
                more = |(m >> (s + 1));
                if (more) begin
                    chk("next_req", send_req, 1);
                end else begin
                    chk("tx_done", tx_done, 1);
                    chk("busy_in_done", busy, 1);
                    @(negedge N_clk);
                    chk("busy_clear", busy, 0);
                    chk("tx_done_pulse", tx_done, 0);
                end
            end
        end
    endtask

    task automatic ign_start(input logic [NUM_DEST-1:0] m, input int len);
        dest_mask  = m;
        dest_ids   = rand_ids();
        pkt_len    = LEN_W'(len);
        tx_payload = rand_pay();
        start      = 1'b1;
        @(negedge N_clk);
        start = 1'b0;
        repeat (3) begin
            chk("ign_busy", busy, 0);
            chk("ign_req", send_req, 0);
            @(negedge N_clk);
        end
    endtask

    task automatic rx_step(input bit v, input bit t,
                           input logic [DATA_W-1:0] d, input bit c);
        rx_exp_t re;
        logic [FLIT_W-1:0] f;
        if (!v && !c) begin
            @(negedge N_clk);
            return;
        end
        if (c) begin
            m_cnt    = 0;
            m_closed = 0;
            m_ovf    = 0;
        end
        if (v) begin
            if (m_closed) m_cnt = 0;
            if (m_cnt < MAX_FLITS) begin
                m_buf[m_cnt] = d;
                m_cnt++;
            end else begin
                m_ovf = 1;
            end
            m_closed = t;
        end
        re.cnt = LEN_W'(m_cnt);
        for (int k = 0; k < MAX_FLITS; k++)
            re.buff[k*DATA_W +: DATA_W] = m_buf[k];
        re.done = v && t;
        re.ovf  = m_ovf;
        rx_q.push_back(re);
        f = FLIT_W'({$urandom, $urandom, $urandom});
        f[FLIT_W-1]    = v;
        f[FLIT_W-2]    = t;
        f[DATA_W-1:0]  = d;
        i_flit   = f;
        rx_clear = c;
        @(negedge N_clk);
        f = FLIT_W'({$urandom, $urandom, $urandom});
        f[FLIT_W-1] = 1'b0;
        i_flit   = f;
        rx_clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] pay;
        N_rst      = 1'b1;
        local_id   = 8'd7;
        start      = 1'b0;
        req_ack    = 1'b0;
        rx_clear   = 1'b0;
        i_flit     = '0;
        dest_mask  = '0;
        dest_ids   = '0;
        pkt_len    = '0;
        tx_payload = '0;
        rx_model_reset();
        repeat (2) @(negedge N_clk);
        chk("rst_busy", busy, 0);
        chk("rst_req", send_req, 0);
        chk("rst_valid", send_data_valid, 0);
        chk("rst_data", send_data, 0);
        chk("rst_src", src_node, 0);
        chk("rst_dest", dest_node, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_count", rx_count, 0);
        N_rst = 1'b0;
        @(negedge N_clk);

        pay = '0;
        pay[31:0]  = 32'hFFFF_FFFF;
        pay[63:32] = 32'h8001_0001;
        run_tx(4'b0001, {8'd0, 8'd0, 8'd0, 8'd4}, 2, pay, 1, 0);

        run_tx(4'b1010, {8'd9, 8'd3, 8'd2, 8'd1}, 3, rand_pay(), 2, 0);

        ign_start(4'b0001, 0);
        ign_start(4'b0000, 3);
        ign_start(4'b0001, MAX_FLITS + 1);
        run_tx(4'b0101, rand_ids(), 4, rand_pay(), 1, 1);

        rx_step(1, 0, 32'hA, 0);
        rx_step(1, 0, 32'hB, 0);
        rx_step(1, 1, 32'hC, 0);
        @(negedge N_clk);
        rx_step(1, 0, 32'hD, 0);

        rx_step(0, 0, 0, 1);
        for (int k = 0; k < MAX_FLITS + 1; k++)
            rx_step(1, k == MAX_FLITS, 32'h100 + k, 0);
        rx_step(1, 0, 32'hE, 1);

        fork
            for (int t = 0; t < 15; t++) begin
                run_tx(NUM_DEST'($urandom_range(1, (1 << NUM_DEST) - 1)),
                       rand_ids(), $urandom_range(1, MAX_FLITS),
                       rand_pay(), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 2)) @(negedge N_clk);
            end
            for (int t = 0; t < 120; t++)
                rx_step($urandom_range(0, 3) != 0,
                        $urandom_range(0, 3) == 0, $urandom,
                        $urandom_range(0, 7) == 0);
        join

        dest_mask  = 4'b0001;
        dest_ids   = rand_ids();
        pkt_len    = LEN_W'(MAX_FLITS);
        tx_payload = rand_pay();
        for (int w = 0; w < MAX_FLITS; w++) begin
            mon_t.dest = dest_ids[ID_W-1:0];
            mon_t.data = tx_payload[w*DATA_W +: DATA_W];
            tx_q.push_back(mon_t);
        end
        start = 1'b1;
        @(negedge N_clk);
        start = 1'b0;
        chk("rst_test_req", send_req, 1);
        req_ack = 1'b1;
        @(negedge N_clk);
        req_ack = 1'b0;
        repeat (2) @(negedge N_clk);
        chk("rst_test_mid_send", send_data_valid, 1);
        #2;
        N_rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_req", send_req, 0);
        chk("arst_valid", send_data_valid, 0);
        chk("arst_data", send_data, 0);
        chk("arst_dest", dest_node, 0);
        chk("arst_src", src_node, 0);
        chk("arst_done", tx_done, 0);
        chk("arst_rx_data", rx_data, 0);
        chk("arst_rx_count", rx_count, 0);
        chk("arst_rx_ovf", rx_overflow, 0);
        chk("arst_rx_done", rx_done, 0);
        tx_q.delete();
        rx_model_reset();
        @(negedge N_clk);
        N_rst = 1'b0;
        @(negedge N_clk);
        run_tx(4'b1001, rand_ids(), 5, rand_pay(), 0, 0);
        rx_step(1, 1, 32'h55, 0);

        repeat (4) @(negedge N_clk);
        chk("tx_queue_empty", tx_q.size(), 0);
        chk("rx_queue_empty", rx_q.size(), 0);
        chk("tx_done_count", seen_done, exp_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
